// File: rtl/pfd_tdc_lock_detect.sv
// rtl/pfd_tdc_lock_detect.sv - PFD up/dn pulse-width TDC with hysteretic lock detector
// Measures signed up/dn pulse widths in clk_i cycles and qualifies lock from the samples.
module pfd_tdc_lock_detect #(
  parameter int Width       = 12,
  parameter int QuietCycles = 64,
  parameter int LockTol     = 2,
  parameter int UnlockTol   = 8,
  parameter int LockCount   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic                    dn_i,
  output logic signed [Width-1:0] tau_o,
  output logic                    tau_valid_o,
  output logic                    tau_sat_o,
  output logic                    locked_o
);

  localparam int QW = $clog2(QuietCycles);
  localparam int GW = $clog2(LockCount + 1);
  localparam logic signed [Width:0] SumMax = {2'b00, {(Width-1){1'b1}}};
  localparam logic signed [Width:0] SumMin = -SumMax;

  typedef enum logic {IDLE, PULSE} state_t;

  logic [1:0] up_sync, dn_sync;
  logic       up_s, dn_s, active;
  assign up_s   = up_sync[1];
  assign dn_s   = dn_sync[1];
  assign active = up_s | dn_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], up_i};
      dn_sync <= {dn_sync[0], dn_i};
    end
  end

  state_t                    state_q, state_d;
  logic signed [Width-1:0]   acc_q, acc_d, emit_tau;
  logic                      sat_q, sat_d, emit, emit_sat;
  logic [QW-1:0]             quiet_q, quiet_d;
  logic [GW-1:0]             good_q, good_d;
  logic                      locked_d;
  logic signed [1:0]         delta;
  logic signed [Width:0]     sum;
  logic [Width-1:0]          mag;

  always_comb begin
    delta = 2'sd0;
    if (up_s && !dn_s)      delta = 2'sd1;
    else if (dn_s && !up_s) delta = -2'sd1;
  end

  assign sum = {acc_q[Width-1], acc_q} + {{(Width-1){delta[1]}}, delta};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    quiet_d  = quiet_q;
    emit     = 1'b0;
    emit_tau = '0;
    emit_sat = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = PULSE;
          acc_d   = {{(Width-2){delta[1]}}, delta};
          sat_d   = 1'b0;
          quiet_d = '0;
        end else if (quiet_q == QW'(QuietCycles - 1)) begin
          emit    = 1'b1;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + QW'(1);
        end
      end
      PULSE: begin
        if (active) begin
          if (sum > SumMax) begin
            acc_d = SumMax[Width-1:0];
            sat_d = 1'b1;
          end else if (sum < SumMin) begin
            acc_d = SumMin[Width-1:0];
            sat_d = 1'b1;
          end else begin
            acc_d = sum[Width-1:0];
          end
        end else begin
          emit     = 1'b1;
          emit_tau = acc_q;
          emit_sat = sat_q;
          state_d  = IDLE;
          quiet_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturation keeps tau_o away from the most negative code, so negation cannot overflow.
  assign mag = tau_o[Width-1] ? (~tau_o + Width'(1)) : tau_o;

  always_comb begin
    good_d   = good_q;
    locked_d = locked_o;
    if (tau_valid_o) begin
      if (mag <= Width'(LockTol) && !tau_sat_o) begin
        good_d = (good_q == GW'(LockCount)) ? good_q : good_q + GW'(1);
        if (good_d == GW'(LockCount)) locked_d = 1'b1;
      end else if (mag > Width'(UnlockTol) || tau_sat_o) begin
        good_d   = '0;
        locked_d = 1'b0;
      end else begin
        good_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      quiet_q     <= '0;
      good_q      <= '0;
      locked_o    <= 1'b0;
      tau_o       <= '0;
      tau_valid_o <= 1'b0;
      tau_sat_o   <= 1'b0;
    end else if (!en_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      quiet_q     <= '0;
      good_q      <= '0;
      locked_o    <= 1'b0;
      tau_valid_o <= 1'b0;
      tau_sat_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      quiet_q     <= quiet_d;
      good_q      <= good_d;
      locked_o    <= locked_d;
      tau_valid_o <= emit;
      if (emit) begin
        tau_o     <= emit_tau;
        tau_sat_o <= emit_sat;
      end
    end
  end

endmodule

// File: tb/tb_pfd_tdc_lock_detect.sv
// tb/tb_pfd_tdc_lock_detect.sv - self-checking bench for pfd_tdc_lock_detect
// Scenario tasks push expected samples to a queue and compare against strobes captured by a monitor.
module tb_pfd_tdc_lock_detect;

  logic clk = 1'b0;
  logic rst_n, en, up, dn;
  logic en6, up6, dn6;
  logic signed [11:0] tau;
  logic tau_valid, tau_sat, locked;
  logic signed [5:0] tau6;
  logic tau_valid6, tau_sat6, locked6;

  always #5 clk = ~clk;

  pfd_tdc_lock_detect u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .dn_i(dn),
    .tau_o(tau), .tau_valid_o(tau_valid), .tau_sat_o(tau_sat), .locked_o(locked)
  );

  pfd_tdc_lock_detect #(.Width(6)) u_dut6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en6), .up_i(up6), .dn_i(dn6),
    .tau_o(tau6), .tau_valid_o(tau_valid6), .tau_sat_o(tau_sat6), .locked_o(locked6)
  );

  typedef struct { logic signed [11:0] tau; logic sat; } samp_t;
  typedef struct { logic signed [11:0] tau; logic sat; int cyc; } obs_t;

  samp_t exp_q[$];
  obs_t  obs_q[$];
  obs_t  mon_o;
  int    cyc = 0;
  int    vectors = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tau_valid) begin
      mon_o.tau = tau;
      mon_o.sat = tau_sat;
      mon_o.cyc = cyc;
      obs_q.push_back(mon_o);
    end
  end

  task automatic wait_obs(input int budget, output obs_t o, output bit ok);
    ok = 1'b0;
    o.tau = '0; o.sat = 1'b0; o.cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive(input int len, input int up_from, input int up_to,
                       input int dn_from, input int dn_to);
    for (int c = 0; c < len; c++) begin
      up = (c >= up_from) && (c < up_to);
      dn = (c >= dn_from) && (c < dn_to);
      @(negedge clk);
    end
    up = 1'b0;
    dn = 1'b0;
  endtask

  task automatic en_pulse();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; en6 = 1'b1;
    up = 1'b0; dn = 1'b0; up6 = 1'b0; dn6 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (tau !== 12'sd0 || tau_valid !== 1'b0 || tau_sat !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tau=%0d valid=%b sat=%b locked=%b, required all 0", tau, tau_valid, tau_sat, locked);
    end
    vectors++;
    if (tau6 !== 6'sd0 || tau_valid6 !== 1'b0 || locked6 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs6: tau=%0d valid=%b locked=%b, required all 0", tau6, tau_valid6, locked6);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_pulse();
    obs_t o; samp_t e; bit ok; int t0;
    en_pulse();
    exp_q.push_back('{12'sd5, 1'b0});
    t0 = cyc;
    drive(5, 0, 5, 0, 0);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || o.tau !== e.tau || o.sat !== e.sat) begin
      errors++;
      $display("FAIL up5_value: seen=%b tau=%0d sat=%b, required tau=%0d sat=%b", ok, o.tau, o.sat, e.tau, e.sat);
    end
    vectors++;
    if (o.cyc - t0 !== 8) begin
      errors++;
      $display("FAIL up5_latency: %0d cycles, required 8", o.cyc - t0);
    end
    repeat (12) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL up5_single_strobe: %0d extra strobes, required 0", obs_q.size());
    end
  endtask

  task automatic test_dn_pulse();
    obs_t o; samp_t e; bit ok;
    en_pulse();
    exp_q.push_back('{-12'sd3, 1'b0});
    drive(3, 0, 0, 0, 3);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || o.tau !== e.tau || o.sat !== e.sat) begin
      errors++;
      $display("FAIL dn3_value: seen=%b tau=%0d sat=%b, required tau=%0d sat=%b", ok, o.tau, o.sat, e.tau, e.sat);
    end
  endtask

  task automatic test_overlap();
    obs_t o; samp_t e; bit ok;
    en_pulse();
    exp_q.push_back('{12'sd4, 1'b0});
    drive(6, 0, 6, 4, 6);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || o.tau !== e.tau || o.sat !== e.sat) begin
      errors++;
      $display("FAIL overlap_tail: seen=%b tau=%0d, required tau=%0d", ok, o.tau, e.tau);
    end
    exp_q.push_back('{12'sd0, 1'b0});
    drive(4, 0, 4, 0, 4);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || o.tau !== e.tau || o.sat !== e.sat) begin
      errors++;
      $display("FAIL overlap_full: seen=%b tau=%0d, required tau=%0d", ok, o.tau, e.tau);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; samp_t e; bit ok;
    en_pulse();
    exp_q.push_back('{12'sd3, 1'b0});
    exp_q.push_back('{-12'sd2, 1'b0});
    drive(6, 0, 3, 4, 6);
    for (int k = 0; k < 2; k++) begin
      wait_obs(20, o, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || o.tau !== e.tau || o.sat !== e.sat) begin
        errors++;
        $display("FAIL b2b_%0d: seen=%b tau=%0d, required tau=%0d", k, ok, o.tau, e.tau);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    en6 = 1'b0;
    @(negedge clk);
    en6 = 1'b1;
    up6 = 1'b1;
    repeat (40) @(negedge clk);
    up6 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tau_valid6) ok = 1'b1;
    end
    vectors++;
    if (!ok || tau6 !== 6'sd31 || tau_sat6 !== 1'b1) begin
      errors++;
      $display("FAIL sat_value: seen=%b tau=%0d sat=%b, required tau=31 sat=1", ok, tau6, tau_sat6);
    end
    @(negedge clk);
    vectors++;
    if (locked6 !== 1'b0) begin
      errors++;
      $display("FAIL sat_locked: locked=%b, required 0", locked6);
    end
  endtask

  task automatic test_lock_hysteresis();
    obs_t o; samp_t e; bit ok;
    en_pulse();
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{(k % 2 == 0) ? 12'sd1 : -12'sd1, 1'b0});
      drive(1, 0, (k % 2 == 0) ? 1 : 0, 0, (k % 2 == 1) ? 1 : 0);
      wait_obs(15, o, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || o.tau !== e.tau || locked !== 1'b0) begin
        errors++;
        $display("FAIL lock_pulse_%0d: seen=%b tau=%0d locked=%b, required tau=%0d locked=0", k, ok, o.tau, locked, e.tau);
      end
    end
    @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_rise: locked=%b, required 1", locked);
    end
    exp_q.push_back('{12'sd5, 1'b0});
    drive(5, 0, 5, 0, 0);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    @(negedge clk);
    vectors++;
    if (!ok || o.tau !== e.tau || locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold_5: seen=%b tau=%0d locked=%b, required tau=%0d locked=1", ok, o.tau, locked, e.tau);
    end
    exp_q.push_back('{-12'sd9, 1'b0});
    drive(9, 0, 0, 0, 9);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    @(negedge clk);
    vectors++;
    if (!ok || o.tau !== e.tau || locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_drop_9: seen=%b tau=%0d locked=%b, required tau=%0d locked=0", ok, o.tau, locked, e.tau);
    end
  endtask

  task automatic test_quiet();
    obs_t o; bit ok; int t0;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (tau !== 12'sd0) begin
      errors++;
      $display("FAIL quiet_reset_tau: tau=%0d, required 0", tau);
    end
    rst_n = 1'b1;
    obs_q.delete();
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      wait_obs(70, o, ok);
      vectors++;
      if (!ok || o.tau !== 12'sd0 || o.sat !== 1'b0 || o.cyc - t0 !== 64 || locked !== 1'b0) begin
        errors++;
        $display("FAIL quiet_%0d: seen=%b tau=%0d period=%0d locked=%b, required tau=0 period=64 locked=0", k, ok, o.tau, o.cyc - t0, locked);
      end
      t0 = o.cyc;
    end
    @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL quiet_lock: locked=%b, required 1", locked);
    end
  endtask

  task automatic test_enable_abort();
    obs_t o; samp_t e; bit ok;
    obs_q.delete();
    exp_q.push_back('{12'sd2, 1'b0});
    drive(2, 0, 2, 0, 0);
    wait_obs(20, o, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || o.tau !== e.tau) begin
      errors++;
      $display("FAIL abort_pre: seen=%b tau=%0d, required tau=%0d", ok, o.tau, e.tau);
    end
    up = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    up = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (locked !== 1'b0 || tau !== e.tau) begin
      errors++;
      $display("FAIL abort_state: locked=%b tau=%0d, required locked=0 tau=%0d", locked, tau, e.tau);
    end
    en = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (obs_q.size() !== 0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_strobe: strobes=%0d locked=%b, required 0 strobes locked=0", obs_q.size(), locked);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up_pulse();
    test_dn_pulse();
    test_overlap();
    test_back_to_back();
    test_saturation();
    test_lock_hysteresis();
    test_quiet();
    test_enable_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
